sync_fifo_th: RTL

SYNC_FIFO_TH -- requirements
Module: sync_fifo_th

---
 rtl/sync_fifo_pkg.sv | 21 ++
 rtl/sync_fifo_th_if.sv | 36 +++
 rtl/sync_fifo_ram.sv | 30 +++
 rtl/sync_fifo_th.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_th threshold FIFO.
package sync_fifo_pkg;

    localparam int DEF_WIDTH     = 64;
    localparam int DEF_DEPTH     = 1024;
    localparam int DEF_AF_MARGIN = 4;
    localparam int DEF_AE_LEVEL  = 4;

    // Smallest n with 2**n >= value.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo_th_if.sv
// Handshake/status bundle between a FIFO user (master) and sync_fifo_th (slave).
interface sync_fifo_th_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CNT_WIDTH = clog2(DEPTH) + 1;

    logic                 wr_en;
    logic [WIDTH-1:0]     din;
    logic                 rd_en;
    logic                 clr_err;
    logic [WIDTH-1:0]     dout;
    logic                 dout_vld;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [CNT_WIDTH-1:0] fifo_cnt;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  dout, dout_vld, full, empty, almost_full, almost_empty,
               fifo_cnt, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output dout, dout_vld, full, empty, almost_full, almost_empty,
               fifo_cnt, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module sync_fifo_ram #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Read-during-write to the same address returns the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_th.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is standard read.
module sync_fifo_th
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic          clk,
    input  logic          rst,
    sync_fifo_th_if.slave bus
);
    localparam int ADDR_WIDTH = clog2(DEPTH);
    localparam int CW         = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic full_q, full_d, empty_q, empty_d;
    logic af_q, af_d, ae_q, ae_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic wr_acc, rd_acc;

    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [WIDTH-1:0]      ram_rdata;
    logic [WIDTH-1:0]      dout_w;

    always_comb begin
        wr_acc   = bus.wr_en && !full_q;
        rd_acc   = bus.rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(rd_acc);
        cnt_d    = cnt_q;
        if (wr_acc && !rd_acc) begin
            cnt_d = cnt_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_d = cnt_q - CW'(1);
        end
        full_d  = (cnt_d == DEPTH_CNT);
        empty_d = (cnt_d == '0);
        af_d    = (cnt_d >= AF_CNT);
        ae_d    = (cnt_d <= AE_CNT);
        // A fresh error event takes priority over a clear in the same cycle.
        ovf_d   = (bus.wr_en && full_q)  || (ovf_q && !bus.clr_err);
        unf_d   = (bus.rd_en && empty_q) || (unf_q && !bus.clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    sync_fifo_ram #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.din),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // The RAM continuously prefetches the next head; a write landing on that
    // head slot in the same cycle is forwarded through a bypass register.
    logic             bypass_q, bypass_d;
    logic [WIDTH-1:0] bypass_data_q, bypass_data_d;

    always_comb begin
        ram_rd_en     = 1'b1;
        ram_rd_addr   = rd_ptr_d;
        bypass_d      = wr_acc && (wr_ptr_q == rd_ptr_d);
        bypass_data_d = bus.din;
        dout_w        = '0;
        if (!empty_q) begin
            dout_w = bypass_q ? bypass_data_q : ram_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_q      <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            bypass_q      <= bypass_d;
            bypass_data_q <= bypass_data_d;
        end
    end

    assign bus.dout_vld = !empty_q;
`else
    // The RAM output is only fresh the cycle after a pop; a shadow register
    // keeps dout stable (and resettable) the rest of the time.
    logic             dout_vld_q, dout_vld_d;
    logic [WIDTH-1:0] dout_hold_q, dout_hold_d;

    always_comb begin
        ram_rd_en   = rd_acc;
        ram_rd_addr = rd_ptr_q;
        dout_vld_d  = rd_acc;
        dout_w      = dout_vld_q ? ram_rdata : dout_hold_q;
        dout_hold_d = dout_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_vld_q  <= 1'b0;
            dout_hold_q <= '0;
        end else begin
            dout_vld_q  <= dout_vld_d;
            dout_hold_q <= dout_hold_d;
        end
    end

    assign bus.dout_vld = dout_vld_q;
`endif

    assign bus.dout         = dout_w;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.fifo_cnt     = cnt_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule
